// File: rtl/util_wdt_recovery.sv
// Recovery controller behind a watchdog: issues timed subsystem resets on timeouts,
// holds off while the subsystem re-initialises, and escalates to a sticky fatal state.
module util_wdt_recovery #(
  parameter int unsigned EVT_W = 16,
  parameter int unsigned RTY_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             cnt_pulse,
  input  logic             timeout_in,
  input  logic             alive_in,
  input  logic [15:0]      rst_width,
  input  logic [31:0]      holdoff,
  input  logic [RTY_W-1:0] max_retry,
  input  logic             clr,
  output logic             sub_rstn,
  output logic             fatal,
  output logic             busy,
  output logic [RTY_W-1:0] retry_cnt,
  output logic [EVT_W-1:0] event_cnt,
  output logic [1:0]       state
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FATAL = 2'd3
  } state_t;

  state_t             state_q, state_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [RTY_W-1:0]   retry_q, retry_n;
  logic [EVT_W-1:0]   evt_q, evt_n;
  logic               timeout_d_q;
  logic               sub_rstn_q, sub_rstn_n;
  logic               fatal_q, fatal_n;
  logic               busy_q, busy_n;
  logic               tedge_c;
  logic [CNT_W-1:0]   width_load_c;

  assign tedge_c      = timeout_in & ~timeout_d_q;
  // A zero width would never reach the count==1 exit, so it is stretched to one tick.
  assign width_load_c = (rst_width == 16'd0) ? CNT_W'(1) : CNT_W'(rst_width);

  // State and counter registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      retry_q     <= '0;
      evt_q       <= '0;
      timeout_d_q <= 1'b0;
      sub_rstn_q  <= 1'b1;
      fatal_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      retry_q     <= retry_n;
      evt_q       <= evt_n;
      timeout_d_q <= timeout_in;
      sub_rstn_q  <= sub_rstn_n;
      fatal_q     <= fatal_n;
      busy_q      <= busy_n;
    end
  end

  // Next-state logic: clr, then enable, then the recovery sequence
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    retry_n = retry_q;
    evt_n   = evt_q;

    if (clr) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
      retry_n = '0;
    end else if (!en) begin
      if (state_q == ST_RESET || state_q == ST_HOLD) begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (tedge_c) begin
            if (evt_q != '1) evt_n = evt_q + EVT_W'(1);
            if (retry_q >= max_retry) begin
              state_n = ST_FATAL;
            end else begin
              retry_n = retry_q + RTY_W'(1);
              state_n = ST_RESET;
              cnt_n   = width_load_c;
            end
          end else if (alive_in) begin
            retry_n = '0;
          end
        end
        ST_RESET: begin
          if (cnt_pulse) begin
            if (cnt_q == CNT_W'(1)) begin
              state_n = ST_HOLD;
              cnt_n   = holdoff;
            end else begin
              cnt_n = cnt_q - CNT_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (cnt_pulse) begin
            if (cnt_q == '0) state_n = ST_IDLE;
            else             cnt_n   = cnt_q - CNT_W'(1);
          end
        end
        ST_FATAL: begin
          state_n = ST_FATAL;
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end

    // Outputs follow the next state so they register alongside it.
    sub_rstn_n = !(state_n == ST_RESET || state_n == ST_FATAL);
    fatal_n    = (state_n == ST_FATAL);
    busy_n     = (state_n == ST_RESET || state_n == ST_HOLD);
  end

  assign sub_rstn  = sub_rstn_q;
  assign fatal     = fatal_q;
  assign busy      = busy_q;
  assign retry_cnt = retry_q;
  assign event_cnt = evt_q;
  assign state     = state_q;

endmodule
